// File: rtl/collision_scanner.sv
// Per-frame bullet table scanner feeding the box-overlap checker.
// Accumulates hit results and drives damage/invulnerability signalling.
module collision_scanner #(
   parameter int unsigned NUM_BULLETS  = 16,
   parameter int unsigned IDX_W        = 4,
   parameter int unsigned INVULN_SCANS = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       px,
   input  logic [7:0]       py,
   input  logic [7:0]       lpx,
   input  logic [7:0]       lpy,
   output logic [IDX_W-1:0] rd_idx,
   input  logic             rd_valid,
   input  logic [7:0]       rd_bx,
   input  logic [7:0]       rd_by,
   input  logic [7:0]       rd_lbx,
   input  logic [7:0]       rd_lby,
   output logic [7:0]       chk_px,
   output logic [7:0]       chk_py,
   output logic [7:0]       chk_lpx,
   output logic [7:0]       chk_lpy,
   output logic [7:0]       chk_bx,
   output logic [7:0]       chk_by,
   output logic [7:0]       chk_lbx,
   output logic [7:0]       chk_lby,
   input  logic             check,
   output logic             busy,
   output logic             done,
   output logic             hit_any,
   output logic [IDX_W-1:0] hit_idx,
   output logic [IDX_W:0]   hit_count,
   output logic             damage,
   output logic             invuln
);

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_t;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_BULLETS - 1);

   state_t           state_q, state_d;
   logic             drain_q;
   logic             s0_vld_q;
   logic [IDX_W-1:0] s0_idx_q;
   logic             s1_vld_q;
   logic             s1_ent_q;
   logic [IDX_W-1:0] s1_idx_q;
   logic [7:0]       inv_cnt_q;
   logic             hit_take;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StScan;
         StScan:  if (rd_idx == LastIdx) state_d = StDrain;
         StDrain: if (drain_q) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Stage 1 holds the bullet currently presented to the checker
   assign hit_take = s1_vld_q && s1_ent_q && check;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         drain_q   <= 1'b0;
         rd_idx    <= '0;
         s0_vld_q  <= 1'b0;
         s0_idx_q  <= '0;
         s1_vld_q  <= 1'b0;
         s1_ent_q  <= 1'b0;
         s1_idx_q  <= '0;
         chk_px    <= '0;
         chk_py    <= '0;
         chk_lpx   <= '0;
         chk_lpy   <= '0;
         chk_bx    <= '0;
         chk_by    <= '0;
         chk_lbx   <= '0;
         chk_lby   <= '0;
         hit_any   <= 1'b0;
         hit_idx   <= '0;
         hit_count <= '0;
         inv_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         drain_q  <= (state_q == StDrain) ? ~drain_q : 1'b0;
         s0_vld_q <= (state_q == StScan);
         s0_idx_q <= rd_idx;
         s1_vld_q <= s0_vld_q;
         if (s0_vld_q) begin
            s1_ent_q <= rd_valid;
            s1_idx_q <= s0_idx_q;
            chk_bx   <= rd_bx;
            chk_by   <= rd_by;
            chk_lbx  <= rd_lbx;
            chk_lby  <= rd_lby;
         end

         if (state_q == StIdle && start) begin
            chk_px    <= px;
            chk_py    <= py;
            chk_lpx   <= lpx;
            chk_lpy   <= lpy;
            hit_any   <= 1'b0;
            hit_idx   <= '0;
            hit_count <= '0;
            rd_idx    <= '0;
         end else begin
            if (state_q == StScan && rd_idx != LastIdx) begin
               rd_idx <= rd_idx + IDX_W'(1);
            end
            if (hit_take) begin
               hit_count <= hit_count + (IDX_W+1)'(1);
               if (!hit_any) begin
                  hit_any <= 1'b1;
                  hit_idx <= s1_idx_q;
               end
            end
         end

         if (state_q == StDone) begin
            if (inv_cnt_q != 8'd0) begin
               inv_cnt_q <= inv_cnt_q - 8'd1;
            end else if (hit_any) begin
               inv_cnt_q <= 8'(INVULN_SCANS);
            end
         end
      end
   end

   assign busy   = (state_q == StScan) || (state_q == StDrain);
   assign done   = (state_q == StDone);
   assign damage = done && (inv_cnt_q == 8'd0) && hit_any;
   assign invuln = (inv_cnt_q != 8'd0);

endmodule
